// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I lab core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath selects and enables, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       imm_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     cur, nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       rd_nz;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, legal, br_ok;
    logic [1:0] imm_code;
    logic       count_en;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign rd_nz        = |instr[11:7];
    assign unused_instr = ^instr[31:15];

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LOAD);
    assign is_st  = (opcode == OP_STORE);
    assign is_br  = (opcode == OP_BRANCH);
    assign is_jal = (opcode == OP_JAL);
    assign legal  = is_r | is_i | is_ld | is_st | is_br | is_jal;
    assign br_ok  = (funct3 == 3'b000) | (funct3 == 3'b001);

    assign imm_code = is_st  ? 2'b01 :
                      is_br  ? 2'b10 :
                      is_jal ? 2'b11 : 2'b00;

    // Every path that finishes an instruction lands in FETCH; TRAP never leaves.
    assign count_en = (nxt == FETCH) && ((cur == EXEC) || (cur == MEM) || (cur == WB));
    assign state    = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == TRAP) illegal <= 1'b1;
            if (count_en)    retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nxt       = cur;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        i_or_d    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        imm_sel   = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        case (cur)
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: begin
                imm_sel = imm_code;
                nxt     = (!legal || (is_br && !br_ok)) ? TRAP : EXEC;
            end
            EXEC: begin
                imm_sel = imm_code;
                nxt     = FETCH;
                if (is_r) begin
                    alu_op = 2'b10;
                    nxt    = WB;
                end else if (is_i) begin
                    alu_src_b = 1'b1;
                    alu_op    = 2'b10;
                    nxt       = WB;
                end else if (is_ld || is_st) begin
                    alu_src_b = 1'b1;
                    nxt       = MEM;
                end else if (is_br) begin
                    alu_op = 2'b01;
                    pc_src = 2'b01;
                    pc_we  = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
                end else if (is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                    reg_we = rd_nz;
                    wb_sel = 2'b10;
                end
            end
            MEM: begin
                imm_sel = imm_code;
                i_or_d  = 1'b1;
                mem_rd  = is_ld;
                mem_wr  = is_st;
                if (mem_ready) nxt = is_ld ? WB : FETCH;
            end
            WB: begin
                reg_we = rd_nz;
                wb_sel = is_ld ? 2'b01 : 2'b00;
                nxt    = FETCH;
            end
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and randomized instructions compared cycle by cycle
// against per-instruction step sequences built from the instruction class.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk, rst, zero, mem_ready;
    logic [31:0]      instr;
    logic             ir_we, pc_we, i_or_d, mem_rd, mem_wr, alu_src_b, reg_we, illegal;
    logic [1:0]       pc_src, imm_sel, alu_op, wb_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .imm_sel(imm_sel), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
        .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ret = 0;
    logic model_ill = 1'b0;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_BAD} kind_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] pk(input logic [2:0] st, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic iod, input logic mrd,
                                       input logic mwr, input logic [1:0] imm, input logic asb,
                                       input logic [1:0] aop, input logic rwe, input logic [1:0] wb);
        return {st, irw, pcw, pcs, iod, mrd, mwr, imm, asb, aop, rwe, wb};
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            default:    return K_BAD;
        endcase
    endfunction

    // Entered at a negedge: drive inputs, settle, compare everything, advance one cycle.
    task automatic cycle(input logic mr, input logic z, input logic [17:0] e, input string tag);
        mem_ready = mr;
        zero      = z;
        #1;
        check(tag, {14'd0, state, ir_we, pc_we, pc_src, i_or_d, mem_rd, mem_wr,
                    imm_sel, alu_src_b, alu_op, reg_we, wb_sel}, {14'd0, e});
        check({tag, "_ret"}, {{(32-CNT_W){1'b0}}, retired}, 32'(model_ret % (1 << CNT_W)));
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, model_ill});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = rb();
        zero      = rb();
        @(negedge clk);
        rst       = 1'b0;
        model_ret = 0;
        model_ill = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input bit abort);
        kind_t      k;
        logic [2:0] f3;
        logic [1:0] imm;
        logic       rdnz, pcw, is_ld;
        k     = classify(ins);
        f3    = ins[14:12];
        rdnz  = (ins[11:7] != 5'd0);
        is_ld = (k == K_LD);
        imm   = (k == K_ST) ? 2'b01 : (k == K_BR) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
        instr = ins;

        for (int i = 0; i < fw; i++)
            cycle(1'b0, rb(), pk(3'd0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00), "fetch_wait");
        cycle(1'b1, rb(), pk(3'd0, 1, 1, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00), "fetch");
        cycle(rb(), rb(), pk(3'd1, 0, 0, 2'b00, 0, 0, 0, imm, 0, 2'b00, 0, 2'b00), "decode");

        if (k == K_BAD || (k == K_BR && f3 != 3'b000 && f3 != 3'b001)) begin
            model_ill = 1'b1;
            for (int i = 0; i < 10; i++)
                cycle(rb(), rb(), pk(3'd5, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00), "trap");
            do_reset();
            return;
        end

        case (k)
            K_R:  cycle(rb(), rb(), pk(3'd2, 0, 0, 2'b00, 0, 0, 0, imm, 0, 2'b10, 0, 2'b00), "exec_r");
            K_I:  cycle(rb(), rb(), pk(3'd2, 0, 0, 2'b00, 0, 0, 0, imm, 1, 2'b10, 0, 2'b00), "exec_i");
            K_LD, K_ST:
                  cycle(rb(), rb(), pk(3'd2, 0, 0, 2'b00, 0, 0, 0, imm, 1, 2'b00, 0, 2'b00), "exec_mem");
            K_BR: begin
                pcw = (f3 == 3'b000) ? z : ~z;
                cycle(rb(), z, pk(3'd2, 0, pcw, 2'b01, 0, 0, 0, imm, 0, 2'b01, 0, 2'b00), "exec_br");
            end
            default:
                  cycle(rb(), rb(), pk(3'd2, 0, 1, 2'b10, 0, 0, 0, imm, 0, 2'b00, rdnz, 2'b10), "exec_jal");
        endcase

        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++) begin
                cycle(1'b0, rb(), pk(3'd3, 0, 0, 2'b00, 1, is_ld, !is_ld, imm, 0, 2'b00, 0, 2'b00), "mem_wait");
                if (abort) begin
                    // Reset lands while the request is still outstanding.
                    do_reset();
                    return;
                end
            end
            cycle(1'b1, rb(), pk(3'd3, 0, 0, 2'b00, 1, is_ld, !is_ld, imm, 0, 2'b00, 0, 2'b00), "mem");
        end

        if (k == K_R || k == K_I || k == K_LD)
            cycle(rb(), rb(), pk(3'd4, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, rdnz,
                                 is_ld ? 2'b01 : 2'b00), "wb");
        model_ret++;
    endtask

    initial begin
        logic [31:0] ins;
        int          pick;
        rst       = 1'b1;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, pk(3'd0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00), "reset");

        run_instr(32'h00700093, 0, 0, 1'b0, 1'b0);
        run_instr(32'h00402ca3, 0, 2, 1'b0, 1'b0);
        run_instr(32'h00400463, 0, 0, 1'b1, 1'b0);
        run_instr(32'h00400463, 0, 0, 1'b0, 1'b0);
        run_instr(32'h0000a103, 1, 0, 1'b0, 1'b0);
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
        run_instr(32'h00402ca3, 0, 2, 1'b0, 1'b1);
        run_instr(32'h00700093, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ins  = $urandom;
            pick = int'($urandom_range(0, 12));
            case (pick)
                0, 1:   ins[6:0] = 7'b0110011;
                2, 3:   ins[6:0] = 7'b0010011;
                4, 5:   ins[6:0] = 7'b0000011;
                6, 7:   ins[6:0] = 7'b0100011;
                8:      begin ins[6:0] = 7'b1100011; ins[14:12] = {2'b00, rb()}; end
                9:      ins[6:0] = 7'b1100011;
                10, 11: ins[6:0] = 7'b1101111;
                default: if (classify(ins) != K_BAD) ins[6:0] = 7'h7f;
            endcase
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(),
                      ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I lab core. It sequences the fetch, decode, execute, memory and writeback steps, and drives every datapath select, including imm_sel to the immediate generator. It handles a ready-based memory handshake and counts retired instructions. It sits between the instruction register/ALU flags and the datapath muxes and enables.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
instr  input  32  instruction register output, stable from DECODE onward
zero  input  1  ALU zero flag, valid in EXEC
mem_ready  input  1  memory completes current access this cycle
ir_we  output  1  load instruction register
pc_we  output  1  load PC
pc_src  output  2  00 PC+4, 01 branch target (PC+imm), 10 jump target (PC+imm)
i_or_d  output  1  memory address select: 0 PC, 1 ALU result
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
imm_sel  output  2  00 I, 01 S, 10 B, 11 J
alu_src_b  output  1  0 rs2, 1 immediate
alu_op  output  2  00 add, 01 sub, 10 use funct3/funct7
reg_we  output  1  register file write enable
wb_sel  output  2  00 ALU, 01 memory data, 10 PC+4
state  output  3  current state (debug)
illegal  output  1  sticky illegal-instruction flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Registered state; outputs decode combinationally from state and instr.
- Reset: state=FETCH, retired=0, illegal=0. An enable is active only in the states listed below; it is 0 in all others.
- Selects default to 0 outside their use: pc_src=00, i_or_d=0, imm_sel=00, alu_src_b=0, alu_op=00, wb_sel=00.
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111. Any other opcode is illegal.
- imm_sel is driven from the opcode in DECODE, EXEC and MEM: I/LOAD 00, STORE 01, BRANCH 10, JAL 11.
- FETCH: mem_rd=1, i_or_d=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_we=1, pc_we=1, pc_src=00, next DECODE.
- DECODE, one cycle:
  - illegal opcode, or BRANCH with funct3 not 000/001 -> TRAP.
  - otherwise -> EXEC.
- EXEC, one cycle:
  - R: alu_src_b=0, alu_op=10 -> WB.
  - I-ALU: alu_src_b=1, alu_op=10 -> WB.
  - LOAD/STORE: alu_src_b=1, alu_op=00 -> MEM.
  - BRANCH: alu_src_b=0, alu_op=01, pc_src=01. pc_we = (funct3==000 & zero) | (funct3==001 & ~zero). Next FETCH.
  - JAL: pc_we=1, pc_src=10, reg_we=(rd!=0), wb_sel=10 -> FETCH.
- MEM: i_or_d=1, mem_rd=1 for LOAD, mem_wr=1 for STORE.
  - The request is held every cycle until mem_ready=1.
  - On ready: LOAD -> WB, STORE -> FETCH.
- WB, one cycle: reg_we=(rd!=0), wb_sel=01 for LOAD else 00 -> FETCH.
- TRAP: illegal=1, all enables 0, stays in TRAP until rst.
- retired increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W. TRAP does not count.
- mem_ready is ignored outside FETCH and MEM.
- rst has priority over all transitions, including mid-MEM with a request pending. On the next edge state=FETCH and the counter/flag clear; no write is completed by the controller.
- Latency with mem_ready tied high, in cycles including FETCH:
  - branch / JAL: 3
  - R / I / store: 4
  - load: 5

Test Plan:
- ADDI x1,x0,7 (0x00700093), mem_ready=1 -> states 0,1,2,4. imm_sel=00 and alu_src_b=1 in EXEC. reg_we=1, wb_sel=00 in WB. retired=1.
- SW (0x00402ca3), mem_ready low 2 cycles in MEM -> imm_sel=01. mem_wr=1, i_or_d=1 for 3 cycles. reg_we never 1. Returns to FETCH; retired increments once.
- BEQ x0,x4,8 (0x00400463): zero=1 -> EXEC has pc_we=1, pc_src=01, imm_sel=10. Repeat with zero=0 -> pc_we=0. Both take 3 cycles.
- LW x2,0(x1) (0x0000a103), FETCH mem_ready delayed 1 cycle -> 6 cycles total. mem_rd in MEM, wb_sel=01, reg_we=1 in WB.
- Illegal 0xFFFFFFFF -> DECODE->TRAP, illegal=1 held for 10 cycles, retired unchanged. rst -> FETCH, illegal=0.
- rst asserted in MEM of SW with mem_ready=0 -> next cycle state=0, mem_wr=0, retired=0. Then the ADDI completes normally.
